// File: rtl/robo_wall_follower.sv
// robo_wall_follower
//   Left-hand wall-following navigation controller for the grid-maze robot.
//   Consumes the head/left wall bits from the map model and issues one-cycle
//   move commands plus the current heading. Tracks its own row/column and
//   stops on the goal cell, on step-budget exhaustion, or when enclosed.
//
// Ports
//   i_clock        only clock
//   i_reset        synchronous, active-high reset
//   i_start        begin navigation (sampled only in IDLE)
//   i_head         1 = wall directly ahead
//   i_left         1 = wall to the left
//   o_acao[2:0]    move pulse: 001 row-1, 010 col-1, 011 row+1, 100 col+1, 000 none
//   o_orientacao   heading: 001 N, 010 W, 011 E, 100 S
//   o_busy         high from start acceptance until DONE/FAIL
//   o_done         sticky, goal reached
//   o_fail         sticky, budget exhausted or enclosed
//   o_steps[15:0]  moves issued (saturating)
//   o_row, o_col   tracked position
//
// state  | meaning
// IDLE   | waiting for start, heading at INIT_ORI
// WAIT   | settle counter running, map updating sensors for the new pose
// DECIDE | sample head/left once and apply the left-hand rule
// DONE   | goal reached, outputs hold until reset
// FAIL   | budget exhausted or enclosed, outputs hold until reset
module robo_wall_follower #(
  parameter int unsigned INIT_ROW  = 1,
  parameter int unsigned INIT_COL  = 1,
  parameter logic [2:0]  INIT_ORI  = 3'b011,
  parameter int unsigned GOAL_ROW  = 18,
  parameter int unsigned GOAL_COL  = 18,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned MAX_STEPS = 1000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_head,
  input  logic        i_left,
  output logic [2:0]  o_acao,
  output logic [2:0]  o_orientacao,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fail,
  output logic [15:0] o_steps,
  output logic [7:0]  o_row,
  output logic [7:0]  o_col
);

  localparam logic [2:0] ORI_N = 3'b001;
  localparam logic [2:0] ORI_W = 3'b010;
  localparam logic [2:0] ORI_E = 3'b011;
  localparam logic [2:0] ORI_S = 3'b100;

  localparam logic [2:0] ACT_NONE    = 3'b000;
  localparam logic [2:0] ACT_ROW_DEC = 3'b001;
  localparam logic [2:0] ACT_COL_DEC = 3'b010;
  localparam logic [2:0] ACT_ROW_INC = 3'b011;
  localparam logic [2:0] ACT_COL_INC = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DECIDE, S_DONE, S_FAIL} state_t;

  function automatic logic [2:0] turn_left(input logic [2:0] ori);
    logic [2:0] res;
    case (ori)
      ORI_N:   res = ORI_W;
      ORI_W:   res = ORI_S;
      ORI_S:   res = ORI_E;
      ORI_E:   res = ORI_N;
      default: res = ori;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] turn_right(input logic [2:0] ori);
    logic [2:0] res;
    case (ori)
      ORI_N:   res = ORI_E;
      ORI_E:   res = ORI_S;
      ORI_S:   res = ORI_W;
      ORI_W:   res = ORI_N;
      default: res = ori;
    endcase
    return res;
  endfunction

  // Heading and move codes differ for E/S, so this is not an identity map.
  function automatic logic [2:0] fwd(input logic [2:0] ori);
    logic [2:0] res;
    case (ori)
      ORI_N:   res = ACT_ROW_DEC;
      ORI_W:   res = ACT_COL_DEC;
      ORI_E:   res = ACT_COL_INC;
      ORI_S:   res = ACT_ROW_INC;
      default: res = ACT_NONE;
    endcase
    return res;
  endfunction

  state_t      r_state, w_state;
  logic [15:0] r_cnt, w_cnt;
  logic [2:0]  r_rturn, w_rturn;
  logic [2:0]  r_acao, w_acao;
  logic [2:0]  r_ori, w_ori;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_fail, w_fail;
  logic [15:0] r_steps, w_steps;
  logic [7:0]  r_row, w_row;
  logic [7:0]  r_col, w_col;

  logic        w_mv_en;
  logic [2:0]  w_mv_ori;
  logic        w_at_goal;

  assign w_at_goal = (r_row == 8'(GOAL_ROW)) && (r_col == 8'(GOAL_COL));

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_rturn  = r_rturn;
    w_acao   = ACT_NONE;
    w_ori    = r_ori;
    w_busy   = r_busy;
    w_done   = r_done;
    w_fail   = r_fail;
    w_steps  = r_steps;
    w_row    = r_row;
    w_col    = r_col;
    w_mv_en  = 1'b0;
    w_mv_ori = r_ori;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state = S_WAIT;
          w_cnt   = 16'(SETTLE);
          w_busy  = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 16'd1) w_state = S_DECIDE;
        else                w_cnt   = r_cnt - 16'd1;
      end
      S_DECIDE: begin
        if (w_at_goal) begin
          w_state = S_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else if (r_steps == 16'(MAX_STEPS)) begin
          w_state = S_FAIL;
          w_busy  = 1'b0;
          w_fail  = 1'b1;
        end else if (!i_left) begin
          w_ori    = turn_left(r_ori);
          w_mv_ori = turn_left(r_ori);
          w_mv_en  = 1'b1;
        end else if (!i_head) begin
          w_mv_en  = 1'b1;
        end else begin
          w_ori   = turn_right(r_ori);
          w_rturn = r_rturn + 3'd1;
          // Fourth consecutive right turn without a move: all sides walled.
          if (r_rturn == 3'd3) begin
            w_state = S_FAIL;
            w_busy  = 1'b0;
            w_fail  = 1'b1;
          end else begin
            w_state = S_WAIT;
            w_cnt   = 16'(SETTLE);
          end
        end
      end
      S_DONE, S_FAIL: begin
        w_state = r_state;
      end
      default: w_state = S_IDLE;
    endcase

    if (w_mv_en) begin
      w_acao = fwd(w_mv_ori);
      case (w_acao)
        ACT_ROW_DEC: w_row = r_row - 8'd1;
        ACT_ROW_INC: w_row = r_row + 8'd1;
        ACT_COL_DEC: w_col = r_col - 8'd1;
        ACT_COL_INC: w_col = r_col + 8'd1;
        default:     w_row = r_row;
      endcase
      if (r_steps != 16'hFFFF) w_steps = r_steps + 16'd1;
      w_rturn = 3'd0;
      w_state = S_WAIT;
      w_cnt   = 16'(SETTLE);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_rturn <= 3'd0;
      r_acao  <= ACT_NONE;
      r_ori   <= INIT_ORI;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
      r_steps <= 16'd0;
      r_row   <= 8'(INIT_ROW);
      r_col   <= 8'(INIT_COL);
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_rturn <= w_rturn;
      r_acao  <= w_acao;
      r_ori   <= w_ori;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_fail  <= w_fail;
      r_steps <= w_steps;
      r_row   <= w_row;
      r_col   <= w_col;
    end
  end

  assign o_acao       = r_acao;
  assign o_orientacao = r_ori;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_fail       = r_fail;
  assign o_steps      = r_steps;
  assign o_row        = r_row;
  assign o_col        = r_col;

endmodule

// File: tb/tb_robo_wall_follower.sv
// Directed bench for robo_wall_follower. The bench plays the map: head/left
// are driven directly per decision. Three instances cover the default build,
// a near goal at (1,3) and a five-move budget.
module tb_robo_wall_follower;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        rst, st, hd, lf;
  logic [2:0]  acao, ori;
  logic        busy, done, fail;
  logic [15:0] steps;
  logic [7:0]  row, col;

  // goal / budget instances share their inputs
  logic        rst2, st2, hd2, lf2;
  logic [2:0]  acao_g, ori_g, acao_m, ori_m;
  logic        busy_g, done_g, fail_g, busy_m, done_m, fail_m;
  logic [15:0] steps_g, steps_m;
  logic [7:0]  row_g, col_g, row_m, col_m;

  int total = 0;
  int bad   = 0;

  robo_wall_follower dut (
    .i_clock(clk), .i_reset(rst), .i_start(st), .i_head(hd), .i_left(lf),
    .o_acao(acao), .o_orientacao(ori), .o_busy(busy), .o_done(done),
    .o_fail(fail), .o_steps(steps), .o_row(row), .o_col(col)
  );

  robo_wall_follower #(.GOAL_ROW(1), .GOAL_COL(3)) dut_g (
    .i_clock(clk), .i_reset(rst2), .i_start(st2), .i_head(hd2), .i_left(lf2),
    .o_acao(acao_g), .o_orientacao(ori_g), .o_busy(busy_g), .o_done(done_g),
    .o_fail(fail_g), .o_steps(steps_g), .o_row(row_g), .o_col(col_g)
  );

  robo_wall_follower #(.MAX_STEPS(5)) dut_m (
    .i_clock(clk), .i_reset(rst2), .i_start(st2), .i_head(hd2), .i_left(lf2),
    .o_acao(acao_m), .o_orientacao(ori_m), .o_busy(busy_m), .o_done(done_m),
    .o_fail(fail_m), .o_steps(steps_m), .o_row(row_m), .o_col(col_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; st = 1'b0; hd = 1'b0; lf = 1'b1;
    tick_n(2);
    total++; if (acao !== 3'b000) begin bad++; $display("FAIL reset_acao got=%0h want=0", acao); end
    total++; if (ori !== 3'b011) begin bad++; $display("FAIL reset_ori got=%0h want=3", ori); end
    total++; if (row !== 8'd1 || col !== 8'd1) begin bad++; $display("FAIL reset_pos got=%0d,%0d want=1,1", row, col); end
    total++; if (steps !== 16'd0) begin bad++; $display("FAIL reset_steps got=%0d want=0", steps); end
    total++; if ({busy, done, fail} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, fail}); end
    rst = 1'b0; st = 1'b1;
    tick();
    st = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", busy); end
    total++; if (acao !== 3'b000) begin bad++; $display("FAIL start_acao got=%0h want=0", acao); end
    total++; if (ori !== 3'b011) begin bad++; $display("FAIL start_ori got=%0h want=3", ori); end
    total++; if (steps !== 16'd0) begin bad++; $display("FAIL start_steps got=%0d want=0", steps); end
  endtask

  // Open corridor east: one col+1 pulse per three cycles, never back to back.
  task automatic test_corridor();
    logic [2:0] prev;
    prev = acao;
    hd = 1'b0; lf = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        total++;
        if (prev !== 3'b000 && acao !== 3'b000) begin
          bad++; $display("FAIL corr_back_to_back got=%0h after=%0h want=0", acao, prev);
        end
        prev = acao;
        if (j < 2) begin
          total++; if (acao !== 3'b000) begin bad++; $display("FAIL corr_idle_acao k=%0d j=%0d got=%0h want=0", k, j, acao); end
        end else begin
          total++; if (acao !== 3'b100) begin bad++; $display("FAIL corr_acao k=%0d got=%0h want=4", k, acao); end
          total++; if (col !== 8'(1 + k) || row !== 8'd1) begin bad++; $display("FAIL corr_pos k=%0d got=%0d,%0d want=1,%0d", k, row, col, 1 + k); end
          total++; if (ori !== 3'b011) begin bad++; $display("FAIL corr_ori k=%0d got=%0h want=3", k, ori); end
          total++; if (steps !== 16'(k)) begin bad++; $display("FAIL corr_steps k=%0d got=%0d want=%0d", k, steps, k); end
        end
      end
    end
  endtask

  // At (1,5) heading E: blocked ahead and left, so turn right to S, then move.
  task automatic test_dead_end();
    hd = 1'b1; lf = 1'b1;
    tick_n(3);
    total++; if (ori !== 3'b100) begin bad++; $display("FAIL dead_ori got=%0h want=4", ori); end
    total++; if (acao !== 3'b000) begin bad++; $display("FAIL dead_acao got=%0h want=0", acao); end
    total++; if (steps !== 16'd4 || col !== 8'd5) begin bad++; $display("FAIL dead_hold got steps=%0d col=%0d want 4,5", steps, col); end
    hd = 1'b0;
    tick_n(3);
    total++; if (acao !== 3'b011) begin bad++; $display("FAIL dead_move_acao got=%0h want=3", acao); end
    total++; if (row !== 8'd2 || steps !== 16'd5) begin bad++; $display("FAIL dead_move got row=%0d steps=%0d want 2,5", row, steps); end
  endtask

  // South to row 5, left turn onto E, then left opening while heading E.
  task automatic test_left_opening();
    hd = 1'b0; lf = 1'b1;
    tick_n(9);
    total++; if (row !== 8'd5 || steps !== 16'd8) begin bad++; $display("FAIL south_run got row=%0d steps=%0d want 5,8", row, steps); end
    lf = 1'b0;
    tick_n(3);
    total++; if (ori !== 3'b011 || acao !== 3'b100) begin bad++; $display("FAIL left_s2e got ori=%0h acao=%0h want 3,4", ori, acao); end
    total++; if (col !== 8'd6 || steps !== 16'd9) begin bad++; $display("FAIL left_s2e_pos got col=%0d steps=%0d want 6,9", col, steps); end
    tick_n(3);
    total++; if (ori !== 3'b001) begin bad++; $display("FAIL left_ori got=%0h want=1", ori); end
    total++; if (acao !== 3'b001) begin bad++; $display("FAIL left_acao got=%0h want=1", acao); end
    total++; if (row !== 8'd4 || col !== 8'd6) begin bad++; $display("FAIL left_pos got=%0d,%0d want=4,6", row, col); end
    total++; if (steps !== 16'd10) begin bad++; $display("FAIL left_steps got=%0d want=10", steps); end
  endtask

  // Fully walled: N->E->S->W with no move, fourth right turn fails.
  task automatic test_enclosed();
    hd = 1'b1; lf = 1'b1;
    tick_n(3);
    total++; if (ori !== 3'b011 || fail !== 1'b0) begin bad++; $display("FAIL encl_r1 got ori=%0h fail=%b want 3,0", ori, fail); end
    tick_n(3);
    total++; if (ori !== 3'b100) begin bad++; $display("FAIL encl_r2 got=%0h want=4", ori); end
    tick_n(3);
    total++; if (ori !== 3'b010 || fail !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL encl_r3 got ori=%0h fail=%b busy=%b want 2,0,1", ori, fail, busy); end
    tick_n(3);
    total++; if (fail !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL encl_fail got fail=%b busy=%b want 1,0", fail, busy); end
    total++; if (steps !== 16'd10 || acao !== 3'b000 || done !== 1'b0) begin bad++; $display("FAIL encl_hold got steps=%0d acao=%0h done=%b want 10,0,0", steps, acao, done); end
    st = 1'b1; hd = 1'b0; lf = 1'b0;
    tick_n(4);
    st = 1'b0;
    total++; if (busy !== 1'b0 || fail !== 1'b1 || acao !== 3'b000) begin bad++; $display("FAIL encl_start_ign got busy=%b fail=%b acao=%0h want 0,1,0", busy, fail, acao); end
    total++; if (row !== 8'd4 || col !== 8'd6 || steps !== 16'd10) begin bad++; $display("FAIL encl_pos_hold got %0d,%0d steps=%0d want 4,6,10", row, col, steps); end
  endtask

  // Reset lands on the DECIDE edge that would have produced the first pulse.
  task automatic test_reset_abort();
    rst = 1'b1; tick();
    rst = 1'b0; hd = 1'b0; lf = 1'b1; st = 1'b1;
    tick();
    st = 1'b0;
    tick_n(2);
    rst = 1'b1;
    tick();
    total++; if (acao !== 3'b000) begin bad++; $display("FAIL abort_acao got=%0h want=0", acao); end
    total++; if (busy !== 1'b0 || fail !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_flags got %b%b%b want 000", busy, done, fail); end
    total++; if (row !== 8'd1 || col !== 8'd1 || steps !== 16'd0 || ori !== 3'b011) begin bad++; $display("FAIL abort_state got %0d,%0d steps=%0d ori=%0h want 1,1,0,3", row, col, steps, ori); end
    rst = 1'b0;
    tick_n(3);
    total++; if (acao !== 3'b000 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle got acao=%0h busy=%b want 0,0", acao, busy); end
  endtask

  task automatic test_goal();
    rst2 = 1'b1; st2 = 1'b0; hd2 = 1'b0; lf2 = 1'b1;
    tick();
    rst2 = 1'b0; st2 = 1'b1;
    tick();
    st2 = 1'b0;
    tick_n(6);
    total++; if (acao_g !== 3'b100 || col_g !== 8'd3 || steps_g !== 16'd2) begin bad++; $display("FAIL goal_move2 got acao=%0h col=%0d steps=%0d want 4,3,2", acao_g, col_g, steps_g); end
    tick_n(2);
    total++; if (done_g !== 1'b0 || busy_g !== 1'b1) begin bad++; $display("FAIL goal_early got done=%b busy=%b want 0,1", done_g, busy_g); end
    tick();
    total++; if (done_g !== 1'b1 || busy_g !== 1'b0 || fail_g !== 1'b0) begin bad++; $display("FAIL goal_done got done=%b busy=%b fail=%b want 1,0,0", done_g, busy_g, fail_g); end
    total++; if (steps_g !== 16'd2 || acao_g !== 3'b000 || col_g !== 8'd3) begin bad++; $display("FAIL goal_hold got steps=%0d acao=%0h col=%0d want 2,0,3", steps_g, acao_g, col_g); end
  endtask

  task automatic test_budget();
    rst2 = 1'b1; st2 = 1'b0; hd2 = 1'b0; lf2 = 1'b1;
    tick();
    rst2 = 1'b0; st2 = 1'b1;
    tick();
    st2 = 1'b0;
    tick_n(15);
    total++; if (steps_m !== 16'd5 || col_m !== 8'd6) begin bad++; $display("FAIL budget_run got steps=%0d col=%0d want 5,6", steps_m, col_m); end
    tick_n(2);
    total++; if (fail_m !== 1'b0 || busy_m !== 1'b1) begin bad++; $display("FAIL budget_early got fail=%b busy=%b want 0,1", fail_m, busy_m); end
    tick();
    total++; if (fail_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) begin bad++; $display("FAIL budget_fail got fail=%b busy=%b done=%b want 1,0,0", fail_m, busy_m, done_m); end
    total++; if (steps_m !== 16'd5 || acao_m !== 3'b000) begin bad++; $display("FAIL budget_hold got steps=%0d acao=%0h want 5,0", steps_m, acao_m); end
  endtask

  initial begin
    rst = 1'b1; st = 1'b0; hd = 1'b0; lf = 1'b1;
    rst2 = 1'b1; st2 = 1'b0; hd2 = 1'b0; lf2 = 1'b1;
    test_reset();
    test_corridor();
    test_dead_end();
    test_left_opening();
    test_enclosed();
    test_reset_abort();
    test_goal();
    test_budget();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/robo_wall_follower.md
# robo_wall_follower

Navigation controller for the grid-maze robot: it is the decision side of the map/sensor interface, consuming the `head`/`left` wall bits produced by the map model and issuing one-cycle movement commands (`acao`) and heading (`orientacao`) back to it. It implements the left-hand wall-following rule and tracks the robot's own row/column. It stops on reaching a goal cell, exceeding a step budget, or detecting an enclosed cell.

## Interface
- `INIT_ROW`, default 1: start row; must match the map's power-up position.
- `INIT_COL`, default 1: start column.
- `INIT_ORI`, default 3'b011: start heading (east).
- `GOAL_ROW`, default 18: goal row.
- `GOAL_COL`, default 18: goal column.
- `SETTLE`, default 2: wait cycles after each command before sampling sensors; minimum legal value is 2.
- `MAX_STEPS`, default 1000: move budget.

Ports:
- `clock` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin navigation; sampled only in IDLE.
- `head` in 1: 1 means a wall is directly ahead.
- `left` in 1: 1 means a wall is to the left.
- `acao` out 3: move command, single-cycle pulse. Encoding: 001 row-1, 010 col-1, 011 row+1, 100 col+1, 000 no action.
- `orientacao` out 3: heading. Encoding: 001 N, 010 W, 011 E, 100 S.
- `busy` out 1: high from start acceptance until DONE or FAIL.
- `done` out 1: sticky; the goal was reached.
- `fail` out 1: sticky; step budget exhausted or robot enclosed.
- `steps` out 16: count of moves issued.
- `row`, `col` out 8 each: tracked position.

## Operation
- States: IDLE, WAIT, DECIDE, DONE, FAIL.
- **IDLE**
  - `acao`=0 and `orientacao`=INIT_ORI.
  - When `start`=1: load the wait counter with SETTLE, set `busy`, go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to DECIDE on the next edge. WAIT therefore lasts exactly SETTLE cycles.
- **DECIDE** samples `head`/`left` once. Checks are evaluated in this priority order:
  1. (`row`,`col`) equals (GOAL_ROW,GOAL_COL): go to DONE.
  2. `steps` equals MAX_STEPS: go to FAIL.
  3. `left`=0:
     - `orientacao` ← L(ori).
     - `acao` ← fwd(L(ori)) for one cycle.
     - Update position, `steps`+1, clear the right-turn counter, go to WAIT.
  4. `head`=0:
     - `acao` ← fwd(ori) for one cycle.
     - Update position, `steps`+1, clear the right-turn counter, go to WAIT.
  5. Otherwise:
     - `orientacao` ← R(ori), no move.
     - Right-turn counter +1.
     - If the counter would reach 4, go to FAIL (enclosed); otherwise go to WAIT.
- Turn tables:
  - Left turn L: N→W, W→S, S→E, E→N.
  - Right turn R: N→E, E→S, S→W, W→N.
- fwd mapping (heading → `acao`):
  - N→001
  - W→010
  - E→100
  - S→011
  - Note that the heading code for E/S differs from the `acao` code for the same direction.
- Position update: N `row`-1, S `row`+1, W `col`-1, E `col`+1.
  - Arithmetic is 8-bit modulo 256 with no bounds guard; the map border walls prevent wrap.
- `steps` saturates at 16'hFFFF.
- DONE and FAIL:
  - `busy`=0, `acao`=0; `orientacao`, `row`, `col` and `steps` hold.
  - `start` is ignored; only `reset` leaves these states.

## Timing
- Reset (synchronous, takes effect on the edge where `reset`=1) sets:
  - state IDLE, `acao`=0, `orientacao`=INIT_ORI
  - `row`=INIT_ROW, `col`=INIT_COL, `steps`=0
  - `busy`=`done`=`fail`=0, right-turn counter 0
- `reset` overrides `start` on the same edge.
- Reset mid-operation aborts immediately; any `acao` pulse is cancelled on that edge.
- Reset does not move the map. System reset must coincide with a map re-initialisation.
- All outputs are registered.
- `acao` is nonzero for exactly one cycle per move, on the cycle following the DECIDE edge. It is never asserted in two consecutive cycles.
- Sensor latency:
  - The map registers `head`/`left` on the edge after it sees the new `acao`/`orientacao`.
  - SETTLE=2 guarantees that DECIDE sees sensors for the updated pose.
- Decision period is SETTLE+1 cycles, i.e. 3 cycles per move or turn at the default.
- `start`→`busy`: 1 cycle.
- The goal check occurs at the DECIDE following the move into the goal cell. `done` rises SETTLE+1 cycles after that move's `acao` pulse.

## Test plan
- **Reset values:** assert `reset` for 2 cycles, then `start`=1 → `acao`=000, `orientacao`=011, `row`=`col`=1, `steps`=0, `busy`=1 one cycle after `start`.
- **Open corridor east:** bench map with `head`=0, `left`=1 → `acao`=100 pulses every 3 cycles, `col` increments by 1 per move, `orientacao` stays 011, `acao` is never high on two consecutive cycles.
- **Left opening:** heading E, `left`=0 → same cycle `orientacao`=001 and `acao`=001, `row` 5→4, `steps`+1.
- **Dead end:** `head`=`left`=1 with right side free → `orientacao` E→S with `acao`=000, then next decision issues `acao`=011.
- **Enclosed:** a fully walled cell gives 4 consecutive right turns → `fail`=1, `busy`=0, `steps` unchanged; `start` is then ignored.
- **Goal / budget / reset:**
  - GOAL=(1,3) on an open row → `done`=1 after 2 moves, `steps`=2.
  - MAX_STEPS=5 on an endless loop → `fail`=1 with `steps`=5.
  - `reset` asserted on the cycle `acao` would pulse → no pulse, IDLE values restored.
